servant_spi_arbiter: RTL and testbench

Two-port Wishbone arbiter between the SERV CPU's instruction bus (read-only) and data bus (read/write) and the single SPI RAM master interface (`servant_spi_master_if`). It grants the shared SPI RAM round-robin, holds the grant for the whole transaction, and enforces the idle gap the SPI master needs between transactions. A one-word instruction buffer answers repeated instruction fetches of the same word without an SPI transaction.

---
 rtl/servant_spi_pkg.sv | 16 +
 rtl/servant_spi_ibuf.sv | 40 ++++
 rtl/servant_spi_arbiter.sv | 120 ++++++++++++
 tb/tb_servant_spi_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_spi_pkg.sv
// Shared types for the SERV SPI RAM subsystem: arbiter state encoding and port IDs.
package servant_spi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_GAP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/servant_spi_ibuf.sv
// One-word instruction buffer: address/data/valid with lookup, fill and write invalidate.
module servant_spi_ibuf
  import servant_spi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int ENABLE_IBUF   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-3:0] lookup_address,
  output logic                     lookup_hit,
  output logic [31:0]              buf_data,
  input  logic                     fill,
  input  logic [ADDRESS_WIDTH-3:0] fill_address,
  input  logic [31:0]              fill_data,
  input  logic                     invalidate,
  input  logic [ADDRESS_WIDTH-3:0] invalidate_address
);

  logic                     buf_valid;
  logic [ADDRESS_WIDTH-3:0] buf_addr;

  // With the buffer disabled, valid never sets, so lookups always miss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (fill) begin
      buf_valid <= (ENABLE_IBUF != 0);
      buf_addr  <= fill_address;
      buf_data  <= fill_data;
    end else if (invalidate && (invalidate_address == buf_addr)) begin
      buf_valid <= 1'b0;
    end
  end

  assign lookup_hit = (ENABLE_IBUF != 0) && buf_valid && (lookup_address == buf_addr);

endmodule

// File: rtl/servant_spi_arbiter.sv
// Round-robin Wishbone arbiter of SERV ibus/dbus onto the SPI RAM master,
// with a post-transaction gap cycle and a one-word instruction buffer.
module servant_spi_arbiter
  import servant_spi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int ENABLE_IBUF   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-3:0] ibus_address,
  input  logic                     ibus_cyc,
  output logic [31:0]              ibus_rd_data,
  output logic                     ibus_ack,
  input  logic [ADDRESS_WIDTH-3:0] dbus_address,
  input  logic [31:0]              dbus_wr_data,
  input  logic [3:0]               dbus_sel,
  input  logic                     dbus_we,
  input  logic                     dbus_cyc,
  output logic [31:0]              dbus_rd_data,
  output logic                     dbus_ack,
  output logic [ADDRESS_WIDTH-3:0] mem_address,
  output logic [31:0]              mem_wr_data,
  output logic [3:0]               mem_sel,
  output logic                     mem_we,
  output logic                     mem_cyc,
  input  logic [31:0]              mem_rd_data,
  input  logic                     mem_ack
);

  arb_state_t  state, state_n;
  port_t       last_grant, last_grant_n;
  logic        ibuf_hit, hit, hit_ack, ibus_req, start_i, start_d;
  logic [31:0] buf_data;

  servant_spi_ibuf #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .ENABLE_IBUF   (ENABLE_IBUF)
  ) u_ibuf (
    .clock              (clock),
    .reset              (reset),
    .lookup_address     (ibus_address),
    .lookup_hit         (ibuf_hit),
    .buf_data           (buf_data),
    .fill               ((state == ARB_GRANT_I) && mem_ack),
    .fill_address       (mem_address),
    .fill_data          (mem_rd_data),
    .invalidate         (start_d && dbus_we),
    .invalidate_address (dbus_address)
  );

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    hit          = 1'b0;
    start_i      = 1'b0;
    start_d      = 1'b0;
    // The fetch just answered from the buffer still holds cyc during its ack cycle.
    ibus_req     = ibus_cyc && !hit_ack;
    case (state)
      ARB_IDLE: begin
        hit = ibus_req && ibuf_hit;
        if (dbus_cyc && (!ibus_req || hit || (last_grant == PORT_I)))
          start_d = 1'b1;
        else if (ibus_req && !hit)
          start_i = 1'b1;
        if (start_d)
          state_n = ARB_GRANT_D;
        else if (start_i)
          state_n = ARB_GRANT_I;
      end
      ARB_GRANT_I: if (mem_ack) begin
        state_n      = ARB_GAP;
        last_grant_n = PORT_I;
      end
      ARB_GRANT_D: if (mem_ack) begin
        state_n      = ARB_GAP;
        last_grant_n = PORT_D;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last_grant  <= PORT_I;
      hit_ack     <= 1'b0;
      mem_address <= '0;
      mem_wr_data <= '0;
      mem_sel     <= '0;
      mem_we      <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      hit_ack    <= hit;
      if (start_d) begin
        mem_address <= dbus_address;
        mem_wr_data <= dbus_wr_data;
        mem_sel     <= dbus_sel;
        mem_we      <= dbus_we;
      end else if (start_i) begin
        mem_address <= ibus_address;
        mem_wr_data <= '0;
        mem_sel     <= '1;
        mem_we      <= 1'b0;
      end
    end
  end

  assign mem_cyc = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);

  // Responses are combinational; acks are dropped if the requester abandoned cyc.
  assign ibus_ack     = ((state == ARB_GRANT_I) && mem_ack && ibus_cyc) || hit_ack;
  assign ibus_rd_data = hit_ack ? buf_data :
                        ((state == ARB_GRANT_I) && mem_ack) ? mem_rd_data : '0;
  assign dbus_ack     = (state == ARB_GRANT_D) && mem_ack && dbus_cyc;
  assign dbus_rd_data = ((state == ARB_GRANT_D) && mem_ack) ? mem_rd_data : '0;

endmodule

// File: tb/tb_servant_spi_arbiter.sv
// Directed bench for servant_spi_arbiter with a small SPI RAM responder model.
module tb_servant_spi_arbiter;

  logic        clock, reset;
  logic [21:0] ibus_address, dbus_address, mem_address;
  logic        ibus_cyc, ibus_ack, dbus_we, dbus_cyc, dbus_ack, mem_we, mem_cyc, mem_ack;
  logic [31:0] ibus_rd_data, dbus_wr_data, dbus_rd_data, mem_wr_data, mem_rd_data;
  logic [3:0]  dbus_sel, mem_sel;

  logic [21:0] nb_ibus_address, nb_mem_address;
  logic        nb_ibus_cyc, nb_ibus_ack, nb_dbus_ack, nb_mem_we, nb_mem_cyc, nb_mem_ack;
  logic [31:0] nb_ibus_rd_data, nb_dbus_rd_data, nb_mem_wr_data;
  logic [3:0]  nb_mem_sel;

  int total = 0;
  int bad = 0;
  int tx_count = 0;
  int nb_tx = 0;
  int lat;
  int tx_before;
  logic [31:0] wmem [logic [21:0]];

  servant_spi_arbiter #(.ADDRESS_WIDTH(24), .ENABLE_IBUF(1)) u_dut (
    .clock(clock), .reset(reset),
    .ibus_address(ibus_address), .ibus_cyc(ibus_cyc), .ibus_rd_data(ibus_rd_data), .ibus_ack(ibus_ack),
    .dbus_address(dbus_address), .dbus_wr_data(dbus_wr_data), .dbus_sel(dbus_sel), .dbus_we(dbus_we),
    .dbus_cyc(dbus_cyc), .dbus_rd_data(dbus_rd_data), .dbus_ack(dbus_ack),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_cyc(mem_cyc), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
  );

  servant_spi_arbiter #(.ADDRESS_WIDTH(24), .ENABLE_IBUF(0)) u_nb (
    .clock(clock), .reset(reset),
    .ibus_address(nb_ibus_address), .ibus_cyc(nb_ibus_cyc), .ibus_rd_data(nb_ibus_rd_data), .ibus_ack(nb_ibus_ack),
    .dbus_address(22'h0), .dbus_wr_data(32'h0), .dbus_sel(4'h0), .dbus_we(1'b0),
    .dbus_cyc(1'b0), .dbus_rd_data(nb_dbus_rd_data), .dbus_ack(nb_dbus_ack),
    .mem_address(nb_mem_address), .mem_wr_data(nb_mem_wr_data), .mem_sel(nb_mem_sel), .mem_we(nb_mem_we),
    .mem_cyc(nb_mem_cyc), .mem_rd_data(32'h0000_0013), .mem_ack(nb_mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unwritten words read as 0xA5000000|addr, except 0x40 which holds 0x00000013.
  function automatic logic [31:0] mem_read(input logic [21:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (a == 22'h40) return 32'h0000_0013;
    return 32'hA500_0000 | {10'b0, a};
  endfunction

  // Main responder: ack two cycles after mem_cyc rises, one-cycle pulse.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_ack     <= 1'b0;
      mem_rd_data <= '0;
      lat         <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_cyc && !mem_ack) begin
        if (lat == 1) begin
          lat         <= 0;
          mem_ack     <= 1'b1;
          mem_rd_data <= mem_read(mem_address);
          if (mem_we) begin
            logic [31:0] w;
            w = mem_read(mem_address);
            for (int b = 0; b < 4; b++)
              if (mem_sel[b]) w[8*b +: 8] = mem_wr_data[8*b +: 8];
            wmem[mem_address] = w;
          end
        end else begin
          lat <= lat + 1;
        end
      end
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) nb_mem_ack <= 1'b0;
    else       nb_mem_ack <= nb_mem_cyc && !nb_mem_ack;
  end

  always @(posedge clock) begin
    if (mem_cyc && mem_ack) tx_count++;
    if (nb_mem_cyc && nb_mem_ack) nb_tx++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic smp;
    @(negedge clock);
  endtask

  function automatic logic ack_of(input int w);
    case (w)
      0:       return ibus_ack;
      1:       return dbus_ack;
      default: return nb_ibus_ack;
    endcase
  endfunction

  task automatic wait_ack(input int which, input string tag);
    int n = 0;
    while (ack_of(which) !== 1'b1 && n < 20) begin
      smp;
      n++;
    end
    check({tag, "_ack"}, {31'b0, ack_of(which)}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    ibus_address = '0; ibus_cyc = 1'b0;
    dbus_address = '0; dbus_wr_data = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    nb_ibus_address = '0; nb_ibus_cyc = 1'b0;
    step;
    smp;
    check("rst_cyc_we_acks", {28'b0, mem_cyc, mem_we, ibus_ack, dbus_ack}, 32'h0);
    check("rst_addr_sel", {6'b0, mem_address, mem_sel}, 32'h0);
    check("rst_wr_data", mem_wr_data, 32'h0);
    check("rst_rd_data", ibus_rd_data | dbus_rd_data, 32'h0);
    step;
    reset = 1'b0;

    // Single dbus write
    dbus_address = 22'h100; dbus_wr_data = 32'hDEADBEEF; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
    smp;
    check("wr_req_same_cycle", {31'b0, mem_cyc}, 32'd0);
    smp;
    check("wr_mem_cyc", {31'b0, mem_cyc}, 32'd1);
    check("wr_mem_addr", {10'b0, mem_address}, 32'h100);
    check("wr_mem_data", mem_wr_data, 32'hDEADBEEF);
    check("wr_mem_sel_we", {27'b0, mem_sel, mem_we}, 32'h1F);
    wait_ack(1, "wr");
    check("wr_no_iack", {31'b0, ibus_ack}, 32'd0);
    step;
    dbus_cyc = 1'b0;
    smp;
    check("wr_gap", {30'b0, mem_cyc, dbus_ack}, 32'd0);

    // Simultaneous requests after reset: D, then I, then D again
    reset = 1'b1;
    step;
    reset = 1'b0;
    ibus_address = 22'h200; ibus_cyc = 1'b1;
    dbus_address = 22'h100; dbus_we = 1'b0; dbus_cyc = 1'b1;
    smp;
    smp;
    check("tie1_d_grant", {9'b0, mem_cyc, mem_we, mem_address}, {9'b0, 1'b1, 1'b0, 22'h100});
    wait_ack(1, "tie1_d");
    check("tie1_d_data", dbus_rd_data, 32'hDEADBEEF);
    smp;
    check("tie1_gap", {31'b0, mem_cyc}, 32'd0);
    smp;
    smp;
    check("rr_i_grant", {9'b0, mem_cyc, mem_we, mem_address}, {9'b0, 1'b1, 1'b0, 22'h200});
    check("rr_i_sel", {28'b0, mem_sel}, 32'hF);
    wait_ack(0, "rr_i");
    check("rr_i_data", ibus_rd_data, 32'hA500_0200);
    check("rr_i_no_dack", {31'b0, dbus_ack}, 32'd0);
    step;
    ibus_cyc = 1'b0;
    smp;
    smp;
    smp;
    check("rr_d_grant", {9'b0, mem_cyc, mem_we, mem_address}, {9'b0, 1'b1, 1'b0, 22'h100});
    wait_ack(1, "rr_d");
    step;
    dbus_cyc = 1'b0;
    smp;

    // Fetch 0x40 from memory, then a buffer hit
    step;
    ibus_address = 22'h40; ibus_cyc = 1'b1;
    wait_ack(0, "fetch1");
    check("fetch1_via_mem", {31'b0, mem_cyc}, 32'd1);
    check("fetch1_data", ibus_rd_data, 32'h0000_0013);
    step;
    ibus_cyc = 1'b0;
    smp;
    step;
    tx_before = tx_count;
    ibus_cyc = 1'b1;
    smp;
    check("hit_not_yet", {30'b0, ibus_ack, mem_cyc}, 32'd0);
    smp;
    check("hit_ack", {30'b0, ibus_ack, mem_cyc}, 32'h2);
    check("hit_data", ibus_rd_data, 32'h0000_0013);
    step;
    ibus_cyc = 1'b0;
    smp;
    check("hit_single_pulse", {31'b0, ibus_ack}, 32'd0);
    check("hit_no_tx", tx_count - tx_before, 32'd0);

    // Write to buffered address invalidates; next fetch goes to memory
    step;
    dbus_address = 22'h40; dbus_wr_data = 32'h12345678; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
    wait_ack(1, "inv_wr");
    step;
    dbus_cyc = 1'b0;
    smp;
    step;
    ibus_address = 22'h40; ibus_cyc = 1'b1;
    smp;
    smp;
    check("inv_miss", {9'b0, ibus_ack, mem_cyc, mem_address}, {9'b0, 1'b0, 1'b1, 22'h40});
    wait_ack(0, "inv_fetch");
    check("inv_fetch_data", ibus_rd_data, 32'h12345678);
    step;
    ibus_cyc = 1'b0;
    smp;

    // Write elsewhere leaves the buffer valid
    step;
    dbus_address = 22'h41; dbus_wr_data = 32'h55AA55AA; dbus_cyc = 1'b1;
    wait_ack(1, "keep_wr");
    step;
    dbus_cyc = 1'b0;
    smp;
    step;
    ibus_cyc = 1'b1;
    smp;
    smp;
    check("keep_hit", {30'b0, ibus_ack, mem_cyc}, 32'h2);
    check("keep_hit_data", ibus_rd_data, 32'h12345678);
    step;
    ibus_cyc = 1'b0;
    smp;

    // Asynchronous reset during a dbus grant
    step;
    dbus_address = 22'h300; dbus_wr_data = 32'hCAFEF00D; dbus_cyc = 1'b1;
    smp;
    smp;
    check("pre_rst_cyc", {31'b0, mem_cyc}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_ctl", {28'b0, mem_cyc, mem_we, ibus_ack, dbus_ack}, 32'h0);
    check("rst_mid_addr_sel", {6'b0, mem_address, mem_sel}, 32'h0);
    check("rst_mid_wdata", mem_wr_data, 32'h0);
    dbus_cyc = 1'b0;
    step;
    reset = 1'b0;
    ibus_address = 22'h40; ibus_cyc = 1'b1;
    smp;
    smp;
    check("post_rst_miss", {9'b0, ibus_ack, mem_cyc, mem_address}, {9'b0, 1'b0, 1'b1, 22'h40});
    wait_ack(0, "post_rst");
    check("post_rst_data", ibus_rd_data, 32'h12345678);
    step;
    ibus_cyc = 1'b0;
    smp;

    // Buffer disabled: same fetch twice is two downstream transactions
    step;
    tx_before = nb_tx;
    nb_ibus_address = 22'h40; nb_ibus_cyc = 1'b1;
    wait_ack(2, "nb1");
    check("nb1_data", nb_ibus_rd_data, 32'h0000_0013);
    step;
    nb_ibus_cyc = 1'b0;
    smp;
    smp;
    step;
    nb_ibus_cyc = 1'b1;
    smp;
    smp;
    check("nb2_no_hit", {30'b0, nb_ibus_ack, nb_mem_cyc}, 32'h1);
    wait_ack(2, "nb2");
    step;
    nb_ibus_cyc = 1'b0;
    smp;
    check("nb_two_tx", nb_tx - tx_before, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
